sar_search_ctrl: RTL
====================

SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the trial value and the result.
REQ-002 SHALL have parameter SETTLE, default 0: number of wait cycles (0..15) between driving a trial and sampling the comparator flags.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a search; sampled only in IDLE.
REQ-006 SHALL have port trial  output  WIDTH  registered value driven to the B input of an external param_comparator; A carries the unknown target.
REQ-007 SHALL have port cmp_equal  input  1  comparator Equal flag (target == trial).
REQ-008 SHALL have port cmp_greater  input  1  comparator Greater flag (target > trial).
REQ-009 SHALL have port cmp_less  input  1  comparator Less flag (target < trial).
REQ-010 SHALL have port busy  output  1  high in TRIAL state.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a search completes.
REQ-012 SHALL have port result  output  WIDTH  search result; updated only when done pulses, held otherwise.
REQ-013 SHALL have port found  output  1  an Equal flag was sampled during the search; updated with result.
REQ-014 SHALL have port err  output  1  sticky: sampled flags were not one-hot; cleared on accepted start.

Function
REQ-015 SHALL implement states IDLE, TRIAL and DONE.
REQ-016 IDLE with start=1: SHALL go to TRIAL, set bit index k=WIDTH-1, accumulator acc=0, trial=1<<(WIDTH-1), settle counter=SETTLE, and clear err.
REQ-017 TRIAL with settle counter>0: SHALL decrement the counter and hold trial.
REQ-018 TRIAL with settle counter=0: SHALL sample the flags and keep bit k in acc when cmp_equal|cmp_greater; otherwise SHALL clear bit k.
REQ-019 On a sample with k>0 and no early exit: SHALL decrement k, drive trial=acc_new|(1<<(k-1)) and reload the counter with SETTLE.
REQ-020 On a sample with k=0, or on early exit (REQ-032): SHALL go to DONE and load result=acc_new and found.
REQ-021 DONE: SHALL assert done for exactly one cycle and return to IDLE; busy SHALL be 0 in DONE and IDLE.
REQ-022 Latency: start sampled in cycle 0 puts done high in cycle WIDTH*(SETTLE+1)+1 when there is no early exit.
REQ-023 start while in TRIAL or DONE SHALL be ignored; a back-to-back start SHALL be accepted only in the IDLE cycle after DONE.
REQ-024 A sample where the three flags are not exactly one-hot SHALL set err; the search continues and keeps the bit when cmp_equal|cmp_greater.
REQ-025 Target 0: every trial is Less, so result=0 and found=0; this is the required behaviour, not an error.
REQ-026 trial SHALL be 0 in IDLE and DONE.

Reset
REQ-027 rst_n low SHALL immediately force IDLE with trial=0, busy=0, done=0, result=0, found=0, err=0, k=0, acc=0 and counter=0.
REQ-028 Reset during TRIAL SHALL abandon the search without a done pulse.
REQ-029 After rst_n deasserts, start SHALL be accepted on the first rising clk edge on which it is sampled high.

Configuration
REQ-030 Macro SAR_EARLY_EXIT_EN SHALL select whether an Equal sample ends the search early.
REQ-031 Without SAR_EARLY_EXIT_EN: every search SHALL take all WIDTH trials.
REQ-032 With SAR_EARLY_EXIT_EN: a sample with cmp_equal=1 SHALL go to DONE immediately, with result=acc_new (equal to the current trial) and found=1.

Verification
REQ-033 WIDTH=8, SETTLE=0, target 0xA5: trials SHALL be 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5, then done in cycle 9 with result=0xA5 and found=1.
REQ-034 SAR_EARLY_EXIT_EN defined, target 0x80: after one trial, done in cycle 2 with result=0x80 and found=1; undefined: done in cycle 9 with result=0x80.
REQ-035 Target 0x00: result=0x00, found=0, err=0; target 0xFF: result=0xFF, found=1 on the last trial.
REQ-036 SETTLE=2, target 0x3C: each trial SHALL be held 3 cycles, done in cycle 25 with result=0x3C; start pulsed mid-search SHALL be ignored.
REQ-037 Force cmp_greater=cmp_less=1 on trial 3: err SHALL be set and held through done, then cleared by the next accepted start.
REQ-038 rst_n asserted in cycle 4 of a search: all outputs SHALL be 0 in the same cycle with no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/sar_search_ctrl.sv
// ============================================================================
// sar_search_ctrl : successive-approximation search driving an external
// comparator. Option macro SAR_EARLY_EXIT_EN ends a search on an Equal sample.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sar_search_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_equal,
  input  logic             cmp_greater,
  input  logic             cmp_less,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0]    K_MSB      = KW'(WIDTH - 1);
  localparam logic [3:0]       SETTLE_C   = 4'(SETTLE);
  localparam logic [WIDTH-1:0] ONE_LSB    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONE_MSB    = ONE_LSB << (WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRIAL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [KW-1:0]    k_q,      k_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] trial_q,  trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       cnt_q,    cnt_d;
  logic             seen_eq_q, seen_eq_d;
  logic             found_q,  found_d;
  logic             err_q,    err_d;

  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_acc_new;
  logic             w_keep;
  logic             w_onehot;
  logic             w_exit;

  assign w_bit     = ONE_LSB << k_q;
  assign w_keep    = cmp_equal | cmp_greater;
  assign w_acc_new = w_keep ? (acc_q | w_bit) : (acc_q & ~w_bit);
  // Odd parity excludes 0 and 2 set flags; the AND term excludes all three.
  assign w_onehot  = (cmp_equal ^ cmp_greater ^ cmp_less) &
                     ~(cmp_equal & cmp_greater & cmp_less);

`ifdef SAR_EARLY_EXIT_EN
  assign w_exit = cmp_equal;
`else
  assign w_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      trial_q   <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      seen_eq_q <= 1'b0;
      found_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      trial_q   <= trial_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      seen_eq_q <= seen_eq_d;
      found_q   <= found_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    trial_d   = trial_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    seen_eq_d = seen_eq_q;
    found_d   = found_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_TRIAL;
          k_d       = K_MSB;
          acc_d     = '0;
          trial_d   = ONE_MSB;
          cnt_d     = SETTLE_C;
          seen_eq_d = 1'b0;
          err_d     = 1'b0;
        end
      end

      S_TRIAL: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          acc_d     = w_acc_new;
          seen_eq_d = seen_eq_q | cmp_equal;
          if (!w_onehot) begin
            err_d = 1'b1;
          end
          if ((k_q == '0) || w_exit) begin
            state_d  = S_DONE;
            trial_d  = '0;
            result_d = w_acc_new;
            found_d  = seen_eq_q | cmp_equal;
          end else begin
            k_d     = k_q - KW'(1);
            trial_d = w_acc_new | (w_bit >> 1);
            cnt_d   = SETTLE_C;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        trial_d = '0;
      end
    endcase
  end

  assign trial  = trial_q;
  assign busy   = (state_q == S_TRIAL);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule

`default_nettype wire
